controle_jogo_rodadas: RTL and testbench

Round-based control unit for the memory game datapath. Each round N (0-based) requires the player to repeat memory positions 0..N. The unit sequences the address counter (E), the round-limit counter (L) and the play register (R), and enforces a per-play timeout with an internal cycle counter. It sits beside the datapath in the top-level game circuit and replaces the single-pass controller.

---
 rtl/controle_jogo_rodadas.sv | 160 ++++++++++++++++
 tb/tb_controle_jogo_rodadas.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/controle_jogo_rodadas.sv
// Round-based controller for the memory game: sequences address (E), round-limit (L)
// and play (R) registers, and times out a play left unanswered in espera.
module controle_jogo_rodadas #(
    parameter int TIMEOUT_CICLOS = 5000,
    parameter int TW             = 13
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          iniciar,
    input  logic          jogada,
    input  logic          igual,
    input  logic          fim_jogada,
    input  logic          fim_rodada,
    output logic          zeraE,
    output logic          contaE,
    output logic          zeraL,
    output logic          contaL,
    output logic          zeraR,
    output logic          registraR,
    output logic          pronto,
    output logic          acertou,
    output logic          errou,
    output logic          timeout,
    output logic [3:0]    db_estado
);

    // Handshake note: jogada is a single-cycle pulse and is only consumed in espera;
    // iniciar is a level, only acted on in inicial and the three final states.

    typedef enum logic [3:0] {
        INICIAL        = 4'd0,
        PREPARACAO     = 4'd1,
        INICIA_RODADA  = 4'd2,
        ESPERA         = 4'd3,
        REGISTRA       = 4'd4,
        COMPARA        = 4'd5,
        PROXIMA_JOGADA = 4'd6,
        PROXIMA_RODADA = 4'd7,
        FINAL_ACERTO   = 4'd8,
        FINAL_ERRO     = 4'd9,
        FINAL_TIMEOUT  = 4'd10
    } estado_t;

    localparam logic [TW-1:0] ULTIMO_CICLO = TW'(TIMEOUT_CICLOS - 1);

    estado_t       estado;
    estado_t       proximo;
    logic [TW-1:0] contagem;
    logic          expirou;

    assign expirou = (contagem == ULTIMO_CICLO);

    always_ff @(posedge clock) begin
        if (reset) begin
            estado <= INICIAL;
        end else begin
            estado <= proximo;
        end
    end

    // Counter is held at zero outside espera, so every entry into espera starts from 0.
    always_ff @(posedge clock) begin
        if (reset) begin
            contagem <= '0;
        end else if (estado == ESPERA) begin
            if (!expirou) begin
                contagem <= contagem + 1'b1;
            end
        end else begin
            contagem <= '0;
        end
    end

    always_comb begin
        proximo   = INICIAL;
        zeraE     = 1'b0;
        contaE    = 1'b0;
        zeraL     = 1'b0;
        contaL    = 1'b0;
        zeraR     = 1'b0;
        registraR = 1'b0;
        pronto    = 1'b0;
        acertou   = 1'b0;
        errou     = 1'b0;
        timeout   = 1'b0;
        db_estado = estado;
        case (estado)
            INICIAL: begin
                zeraE   = 1'b1;
                zeraL   = 1'b1;
                zeraR   = 1'b1;
                proximo = iniciar ? PREPARACAO : INICIAL;
            end
            PREPARACAO: begin
                zeraE   = 1'b1;
                zeraL   = 1'b1;
                zeraR   = 1'b1;
                proximo = INICIA_RODADA;
            end
            INICIA_RODADA: begin
                zeraE   = 1'b1;
                proximo = ESPERA;
            end
            ESPERA: begin
                // A press on the expiry cycle still counts as a play.
                if (jogada) begin
                    proximo = REGISTRA;
                end else if (expirou) begin
                    proximo = FINAL_TIMEOUT;
                end else begin
                    proximo = ESPERA;
                end
            end
            REGISTRA: begin
                registraR = 1'b1;
                proximo   = COMPARA;
            end
            COMPARA: begin
                if (!igual) begin
                    proximo = FINAL_ERRO;
                end else if (!fim_jogada) begin
                    proximo = PROXIMA_JOGADA;
                end else if (!fim_rodada) begin
                    proximo = PROXIMA_RODADA;
                end else begin
                    proximo = FINAL_ACERTO;
                end
            end
            PROXIMA_JOGADA: begin
                contaE  = 1'b1;
                proximo = ESPERA;
            end
            PROXIMA_RODADA: begin
                contaL  = 1'b1;
                proximo = INICIA_RODADA;
            end
            FINAL_ACERTO: begin
                pronto  = 1'b1;
                acertou = 1'b1;
                proximo = iniciar ? PREPARACAO : FINAL_ACERTO;
            end
            FINAL_ERRO: begin
                pronto  = 1'b1;
                errou   = 1'b1;
                proximo = iniciar ? PREPARACAO : FINAL_ERRO;
            end
            FINAL_TIMEOUT: begin
                pronto  = 1'b1;
                errou   = 1'b1;
                timeout = 1'b1;
                proximo = iniciar ? PREPARACAO : FINAL_TIMEOUT;
            end
            default: begin
                db_estado = 4'hF;
                proximo   = INICIAL;
            end
        endcase
    end

endmodule

// File: tb/tb_controle_jogo_rodadas.sv
// Bench for controle_jogo_rodadas: behavioural datapath, randomized games, and a
// scoreboard that compares each finished game against outcomes computed from the game rules.
module tb_controle_jogo_rodadas;

    localparam int T       = 8;
    localparam int RODADAS = 4;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       iniciar = 1'b0;
    logic       jogada = 1'b0;
    logic       igual, fim_jogada, fim_rodada;
    logic       zeraE, contaE, zeraL, contaL, zeraR, registraR;
    logic       pronto, acertou, errou, timeout;
    logic [3:0] db_estado;

    controle_jogo_rodadas #(.TIMEOUT_CICLOS(T), .TW(4)) dut (
        .clock(clock), .reset(reset), .iniciar(iniciar), .jogada(jogada),
        .igual(igual), .fim_jogada(fim_jogada), .fim_rodada(fim_rodada),
        .zeraE(zeraE), .contaE(contaE), .zeraL(zeraL), .contaL(contaL),
        .zeraR(zeraR), .registraR(registraR), .pronto(pronto), .acertou(acertou),
        .errou(errou), .timeout(timeout), .db_estado(db_estado)
    );

    always #5 clock = ~clock;

    // Datapath model: address/limit counters, play register and sequence memory.
    logic [3:0] mem [RODADAS];
    logic [1:0] reg_e, reg_l;
    logic [3:0] reg_r, play_val;

    always @(posedge clock) begin
        if (zeraE) reg_e <= '0; else if (contaE) reg_e <= reg_e + 2'd1;
        if (zeraL) reg_l <= '0; else if (contaL) reg_l <= reg_l + 2'd1;
        if (zeraR) reg_r <= '0; else if (registraR) reg_r <= play_val;
    end
    assign igual      = (reg_r == mem[reg_e]);
    assign fim_jogada = (reg_e == reg_l);
    assign fim_rodada = (reg_l == 2'(RODADAS - 1));

    int checks = 0;
    int errors = 0;
    logic [15:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference outcome of a game: kind 0 = all correct, 1 = wrong play, 2 = no play.
    function automatic logic [15:0] expected_game(input int kind, input int rb, input int pb);
        int cl, ce;
        logic [3:0] code;
        logic [3:0] flags;
        if (kind == 0) begin
            cl = RODADAS - 1;
            ce = 0;
            for (int n = 0; n < RODADAS; n++) ce += n;
        end else begin
            cl = rb;
            ce = pb;
            for (int n = 0; n < rb; n++) ce += n;
        end
        case (kind)
            0:       begin code = 4'd8;  flags = 4'b1100; end
            1:       begin code = 4'd9;  flags = 4'b1010; end
            default: begin code = 4'd10; flags = 4'b1011; end
        endcase
        return {code, flags, 4'(cl), 4'(ce)};
    endfunction

    // Monitor: counts datapath commands, measures espera runs, pops on game completion.
    int         cnt_l, cnt_e, run_espera;
    logic       prev_pronto;
    logic [3:0] prev_estado;
    logic [15:0] exp_item;

    always @(negedge clock) begin
        if (reset) begin
            cnt_l = 0; cnt_e = 0; run_espera = 0;
            prev_pronto = 1'b0;
        end else begin
            if (db_estado == 4'd1) begin cnt_l = 0; cnt_e = 0; end
            if (contaL) cnt_l++;
            if (contaE) cnt_e++;
            if (db_estado == 4'd10 && prev_estado == 4'd3)
                check("timeout_espera_cycles", run_espera, T);
            if (db_estado == 4'd3) run_espera++; else run_espera = 0;
            if (pronto && !prev_pronto) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_completion", {db_estado, pronto}, 0);
                end else begin
                    exp_item = exp_q.pop_front();
                    check("game_result", {db_estado, pronto, acertou, errou, timeout,
                          4'(cnt_l), 4'(cnt_e)}, exp_item);
                end
            end
            prev_pronto = pronto;
        end
        prev_estado = db_estado;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_espera(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (db_estado == 4'd3) begin ok = 1'b1; return; end
            tick();
        end
        check("wait_espera_expired", db_estado, 3);
    endtask

    task automatic wait_pronto();
        logic [3:0] s;
        for (int i = 0; i < 100; i++) begin
            if (pronto) begin
                s = db_estado;
                repeat ($urandom_range(1, 4)) tick();
                check("final_hold", db_estado, s);
                return;
            end
            tick();
        end
        check("wait_pronto_expired", pronto, 1);
    endtask

    // One play at position p; returns with the FSM in compara.
    task automatic do_play(input int p, input bit correct, input bit late, output bit ok);
        int d;
        wait_espera(ok);
        if (!ok) return;
        d = late ? T - 1 : $urandom_range(0, T - 1);
        repeat (d) tick();
        play_val = correct ? mem[p] : mem[p] ^ 4'($urandom_range(1, 15));
        jogada = 1'b1;
        tick();
        jogada = 1'b0;
        check("registra_state", {db_estado, registraR, timeout}, {4'd4, 1'b1, 1'b0});
        tick();
        check("compara_state", {db_estado, registraR}, {4'd5, 1'b0});
    endtask

    task automatic start_game();
        iniciar = 1'b1;
        tick();
        iniciar = 1'b0;
        check("iniciar_to_preparacao", db_estado, 1);
        tick();
        tick();
        check("espera_after_start", db_estado, 3);
    endtask

    task automatic play_game(input int kind, input int rb, input int pb, input bit late);
        bit ok;
        for (int n = 0; n < RODADAS; n++) mem[n] = 4'($urandom_range(0, 15));
        exp_q.push_back(expected_game(kind, rb, pb));
        start_game();
        for (int n = 0; n < RODADAS; n++) begin
            for (int p = 0; p <= n; p++) begin
                if (kind != 0 && n == rb && p == pb) begin
                    if (kind == 1) do_play(p, 1'b0, late, ok);
                    wait_pronto();
                    return;
                end
                do_play(p, 1'b1, late, ok);
                if (!ok) return;
            end
        end
        wait_pronto();
    endtask

    initial begin
        int kind, rb, pb;
        bit ok;
        play_val = '0;
        for (int n = 0; n < RODADAS; n++) mem[n] = '0;

        repeat (3) tick();
        check("reset_state", db_estado, 0);
        check("reset_outputs", {zeraE, zeraL, zeraR, contaE, contaL, registraR,
              pronto, acertou, errou, timeout}, 10'b1110000000);
        reset = 1'b0;
        repeat (3) tick();
        check("idle_held", {db_estado, zeraE, zeraL, zeraR, pronto}, {4'd0, 4'b1110});

        play_game(0, 0, 0, 1'b0);
        play_game(1, 2, 1, 1'b0);
        play_game(2, 1, 0, 1'b0);
        play_game(0, 0, 0, 1'b1);

        // Reset while in compara, then a stray jogada in inicial.
        start_game();
        do_play(0, 1'b1, 1'b0, ok);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("reset_from_compara", db_estado, 0);
        jogada = 1'b1;
        tick();
        jogada = 1'b0;
        tick();
        check("jogada_ignored_inicial", db_estado, 0);

        for (int g = 0; g < 10; g++) begin
            kind = $urandom_range(0, 2);
            rb   = $urandom_range(0, RODADAS - 1);
            pb   = $urandom_range(0, rb);
            play_game(kind, rb, pb, 1'b0);
        end

        repeat (3) tick();
        check("scoreboard_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "simulation time limit");
    end

endmodule
